// File: rtl/pe_dma_mem_arb.sv
// Round-robin arbiter of lane DMA requesters onto one memory port, in-order read tags.
// Define PE_DMA_ARB_PRIORITY_EN to give requester 0 fixed priority over the RR group.
module pe_dma_mem_arb #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [$clog2(MAX_OUT):0]  rd_outstanding,
  output logic                      err_unexp_rsp
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  logic [TW-1:0]      rr_ptr;
  logic [TW-1:0]      rr_nxt;
  logic               free;
  logic               full;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_any;
  logic [TW-1:0]      gnt_idx;
  logic               push;
  logic               pop;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [TW-1:0]      tag_mem [MAX_OUT];
  int                 idx;

  always_comb begin
    free = !mem_valid || mem_ready;
    full = rd_outstanding == CW'(MAX_OUT);
    elig = req_valid & (req_write | {NUM_REQ{!full}});
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
`ifdef PE_DMA_ARB_PRIORITY_EN
    if (elig[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end
`endif
    if (!free || reset_poweron) gnt_any = 1'b0;
  end

  always_comb begin
    req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    push      = gnt_any && !req_write[gnt_idx];
    pop       = mem_rsp_valid && (rd_outstanding != '0);
    rr_nxt    = (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
`ifdef PE_DMA_ARB_PRIORITY_EN
      // requester 0 sits outside the rotation
      if (gnt_idx != '0) rr_ptr <= rr_nxt;
`else
      rr_ptr <= rr_nxt;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (gnt_any) begin
      mem_valid <= 1'b1;
      mem_write <= req_write[gnt_idx];
      mem_addr  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
      mem_wdata <= req_wdata[gnt_idx*DATA_W +: DATA_W];
    end else if (free) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      rsp_valid <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
      if (pop) rsp_data <= mem_rsp_data;
      if (mem_rsp_valid && rd_outstanding == '0) err_unexp_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_dma_mem_arb.sv
// Bench for pe_dma_mem_arb: directed scenarios plus random traffic vs a queue model.
// Build with PE_DMA_ARB_PRIORITY_EN to check the priority variant.
module tb_pe_dma_mem_arb;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int DW = 64;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            reset_poweron = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic            mem_valid;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready = 1'b0;
  logic            mem_rsp_valid = 1'b0;
  logic [DW-1:0]   mem_rsp_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [2:0]      rd_outstanding;
  logic            err_unexp_rsp;

  pe_dma_mem_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rd_outstanding(rd_outstanding), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // behavioural model state
  int          m_ptr = 0;
  bit          m_mvalid = 0;
  bit          m_mwrite = 0;
  logic [AW-1:0] m_maddr = '0;
  logic [DW-1:0] m_mwdata = '0;
  int          m_q[$];
  logic [N-1:0]  m_rsp_valid = '0;
  logic [DW-1:0] m_rsp_data = '0;
  bit          m_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit eligible(int i);
    return req_valid[i] && (req_write[i] || m_q.size() < MO);
  endfunction

  function automatic int exp_grant();
    if (reset_poweron) return -1;
    if (m_mvalid && !mem_ready) return -1;
`ifdef PE_DMA_ARB_PRIORITY_EN
    if (eligible(0)) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (eligible((m_ptr + k) % N)) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      m_ptr = 0; m_mvalid = 0; m_mwrite = 0; m_maddr = '0; m_mwdata = '0;
      m_q.delete(); m_rsp_valid = '0; m_rsp_data = '0; m_err = 0;
    end else begin
      int g;
      bit fr;
      g  = exp_grant();
      fr = !m_mvalid || mem_ready;
      m_rsp_valid = '0;
      if (mem_rsp_valid) begin
        if (m_q.size() > 0) begin
          m_rsp_valid = N'(1) << m_q.pop_front();
          m_rsp_data  = mem_rsp_data;
        end else m_err = 1;
      end
      if (g >= 0) begin
        if (!req_write[g]) m_q.push_back(g);
        m_mvalid = 1;
        m_mwrite = req_write[g];
        m_maddr  = req_addr[g*AW +: AW];
        m_mwdata = req_wdata[g*DW +: DW];
`ifdef PE_DMA_ARB_PRIORITY_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end else if (fr) m_mvalid = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      int g;
      g = exp_grant();
      chk("req_ready", 64'(req_ready), g < 0 ? 64'd0 : 64'(1) << g);
      chk("mem_valid", 64'(mem_valid), 64'(m_mvalid));
      if (m_mvalid) begin
        chk("mem_write", 64'(mem_write), 64'(m_mwrite));
        chk("mem_addr", 64'(mem_addr), 64'(m_maddr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_mwdata));
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      if (m_rsp_valid != '0) chk("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
      chk("rd_outstanding", 64'(rd_outstanding), 64'(m_q.size()));
      chk("err_unexp_rsp", 64'(err_unexp_rsp), 64'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    req_valid = '0; req_write = '0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0;
    step();
    step();
    reset_poweron = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    reset_poweron = 1'b1;
    req_valid = '1;
    #2;
    chk("rst req_ready", 64'(req_ready), 0);
    chk("rst mem_valid", 64'(mem_valid), 0);
    chk("rst mem_addr", 64'(mem_addr), 0);
    chk("rst rsp_data", 64'(rsp_data), 0);
    chk("rst rd_outstanding", 64'(rd_outstanding), 0);
    chk("rst err", 64'(err_unexp_rsp), 0);
    mon_en = 1'b1;
    do_reset();

    // continuous reads from all, responses returning
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i * 16);
    req_valid = '1; mem_ready = 1'b1; mem_rsp_data = 64'h1234;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("rr grant", 64'(req_ready), 64'(1) << (k % N));
      if (k > 0) chk("rr mem_valid", 64'(mem_valid), 1);
      step();
      mem_rsp_valid = 1'b1;
    end
    do_reset();

    // stall holds the request
    req_addr[2*AW +: AW] = 24'h000100;
    req_addr[0 +: AW] = 24'h000abc;
    req_valid = 4'b0100; mem_ready = 1'b0;
    #2 chk("stall grant", 64'(req_ready), 4);
    step();
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall ready", 64'(req_ready), 0);
      chk("stall addr", 64'(mem_addr), 64'h100);
      step();
    end
    mem_ready = 1'b1;
    #2;
    chk("stall addr last", 64'(mem_addr), 64'h100);
    chk("stall next grant", 64'(req_ready), 1);
    do_reset();

    // tag FIFO full: reads stall, write still granted
    req_valid = 4'b0001; mem_ready = 1'b1;
    for (int k = 0; k < MO; k++) begin
      #2 chk("fill grant", 64'(req_ready), 1);
      step();
    end
    #2;
    chk("full count", 64'(rd_outstanding), MO);
    chk("full stall", 64'(req_ready), 0);
    req_valid = 4'b0011; req_write = 4'b0010;
    #2 chk("full write grant", 64'(req_ready), 2);
    step();
    req_valid = 4'b0001; req_write = '0;
    #2;
    chk("full mem_write", 64'(mem_write), 1);
    chk("full still", 64'(req_ready), 0);
    do_reset();

    // in-order response routing
    mem_ready = 1'b1;
    req_valid = 4'b1000;
    #2 chk("route g3", 64'(req_ready), 8);
    step();
    req_valid = 4'b0010;
    #2 chk("route g1", 64'(req_ready), 2);
    step();
    req_valid = '0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'hAAAA;
    step();
    mem_rsp_data = 64'hBBBB;
    #2;
    chk("route rsp3", 64'(rsp_valid), 8);
    chk("route data3", 64'(rsp_data), 64'hAAAA);
    step();
    mem_rsp_valid = 1'b0;
    #2;
    chk("route rsp1", 64'(rsp_valid), 2);
    chk("route data1", 64'(rsp_data), 64'hBBBB);
    step();
    #2 chk("route idle", 64'(rsp_valid), 0);

    // unexpected response
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    #2;
    chk("unexp rsp", 64'(rsp_valid), 0);
    chk("unexp err", 64'(err_unexp_rsp), 1);
    step(); step();
    #2 chk("unexp sticky", 64'(err_unexp_rsp), 1);
    do_reset();
    #2 chk("unexp cleared", 64'(err_unexp_rsp), 0);

    // requesters 0 and 2 contending
    req_valid = 4'b0101; req_write = 4'b0101; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
`ifdef PE_DMA_ARB_PRIORITY_EN
      chk("prio grant", 64'(req_ready), 1);
`else
      chk("alt grant", 64'(req_ready), (k % 2) ? 4 : 1);
`endif
      step();
    end
    do_reset();

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      step();
      reset_poweron = ($urandom_range(0, 399) == 0);
      req_valid = N'($urandom);
      req_write = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW]  = AW'($urandom);
        req_wdata[i*DW +: DW] = {$urandom, $urandom};
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                       : ($urandom_range(0, 60) == 0);
      mem_rsp_data = {$urandom, $urandom};
    end
    step();
    reset_poweron = 1'b0;
    step(); step();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_dma_mem_arb.md
PE_DMA_MEM_ARB -- requirements
Module: pe_dma_mem_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of lane DMA requesters sharing one memory port (2..8).
REQ-002 Parameter ADDR_W, default 24, memory word address width.
REQ-003 Parameter DATA_W, default 64, memory data width.
REQ-004 Parameter MAX_OUT, default 4, maximum outstanding reads (power of 2, 2..16).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset_poweron  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester request valid.
REQ-008 req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
REQ-009 req_write  in  NUM_REQ  1 = write, 0 = read.
REQ-010 req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  NUM_REQ*DATA_W  packed write data.
REQ-012 mem_valid / mem_write / mem_addr / mem_wdata  out  1/1/ADDR_W/DATA_W  registered memory request.
REQ-013 mem_ready  in  1  memory accepts request when mem_valid&mem_ready.
REQ-014 mem_rsp_valid / mem_rsp_data  in  1/DATA_W  in-order read return.
REQ-015 rsp_valid / rsp_data  out  NUM_REQ/DATA_W  routed read response, one-hot valid.
REQ-016 rd_outstanding  out  log2(MAX_OUT)+1  current tag-FIFO occupancy.
REQ-017 err_unexp_rsp  out  1  sticky: response received with no read outstanding.

Function
REQ-018 Output register SHALL be "free" when mem_valid=0 or mem_valid&mem_ready in the same cycle.
REQ-019 Arbitration SHALL occur only in free cycles; exactly one valid requester is granted via req_ready, others see 0.
REQ-020 Round-robin: after granting i, search order SHALL start at (i+1) mod NUM_REQ; reset pointer = 0.
REQ-021 Granted request SHALL appear on mem_* the next cycle (1-cycle latency) and hold stable until mem_ready.
REQ-022 A granted read SHALL push its requester index into the tag FIFO in the grant cycle.
REQ-023 When rd_outstanding == MAX_OUT, read requests SHALL be ineligible; writes remain eligible and are granted by round-robin.
REQ-024 mem_rsp_valid SHALL pop the tag FIFO; next cycle rsp_valid[tag]=1 and rsp_data=registered mem_rsp_data, for exactly one cycle.
REQ-025 Simultaneous push and pop SHALL leave rd_outstanding unchanged; pop frees a slot only from the following cycle.
REQ-026 mem_rsp_valid with empty FIFO SHALL be dropped (no rsp_valid) and set err_unexp_rsp until reset.
REQ-027 Writes SHALL generate no response and no tag.
REQ-028 With no valid requests in a free cycle, req_ready=0 and mem_valid deasserts.

Reset
REQ-029 On reset_poweron: req_ready=0, mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rd_outstanding=0, err_unexp_rsp=0, RR pointer=0.
REQ-030 Reset mid-transaction SHALL discard the held request and all tags; responses arriving after reset set err_unexp_rsp.

Configuration
REQ-031 With PE_DMA_ARB_PRIORITY_EN defined, requester 0 SHALL win whenever eligible and valid, RR among 1..NUM_REQ-1, and a grant to requester 0 SHALL NOT move the pointer; without it, pure round-robin over all requesters.

Verification
REQ-032 All 4 requesters reading continuously, mem_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, mem_valid from cycle 1.
REQ-033 Requester 2 read addr 0x000100, mem_ready held 0 for 3 cycles -> mem_addr stable 0x000100 for 4 cycles, no further grant.
REQ-034 5 reads issued, no responses, MAX_OUT=4 -> rd_outstanding=4, 5th read stalled, concurrent write from requester 1 still granted.
REQ-035 Reads from 3 then 1, mem returns 0xAAAA then 0xBBBB -> rsp_valid[3] with 0xAAAA, next rsp_valid[1] with 0xBBBB.
REQ-036 mem_rsp_valid with rd_outstanding=0 -> no rsp_valid, err_unexp_rsp=1 until reset_poweron.
REQ-037 PE_DMA_ARB_PRIORITY_EN defined, requesters 0 and 2 continuous -> requester 0 granted every free cycle; undefined -> alternates 0,2.
